pll_drp_reconfig: RTL

Dynamic-reconfiguration controller that drives the DRP port of the pll core (DADDR/DI/DEN/DWE in, DO/DRDY out), which is currently tied off.
- On START it holds the pll in reset.
- For each streamed config entry it performs a read-modify-write of one DRP register.
- It then releases reset and waits for LOCKED.
- It sits directly upstream of pll and shares its DCLK domain.

---
 rtl/pll_drp_pkg.sv | 39 +++
 rtl/drp_lock_sync.sv | 28 ++
 rtl/pll_drp_reconfig.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_drp_pkg.sv
// Shared definitions for the pll DRP reconfiguration controller and the
// pll wrappers around it: DRP bus widths, LOCKED synchroniser depth,
// controller state encoding, error codes and the read-modify-write merge.
package pll_drp_pkg;

    localparam int DRP_AW          = 7;
    localparam int DRP_DW          = 16;
    localparam int LOCK_SYNC_DEPTH = 2;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DRDY   = 2'd1;
    localparam logic [1:0] ERR_LOCK   = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HOLD    = 4'd1,
        ST_ENTRY   = 4'd2,
        ST_RD      = 4'd3,
        ST_WRD     = 4'd4,
        ST_WR      = 4'd5,
        ST_WWR     = 4'd6,
        ST_RVFY    = 4'd7,
        ST_WRV     = 4'd8,
        ST_RELEASE = 4'd9,
        ST_WLOCK   = 4'd10,
        ST_ERROR   = 4'd11
    } state_e;

    // Keep the old register bit where mask is 1, take the new bit where mask is 0.
    function automatic logic [DRP_DW-1:0] rmw_merge(
        input logic [DRP_DW-1:0] old_v,
        input logic [DRP_DW-1:0] mask_v,
        input logic [DRP_DW-1:0] data_v
    );
        return (old_v & mask_v) | (data_v & ~mask_v);
    endfunction

endpackage

// File: rtl/drp_lock_sync.sv
// Multi-flop synchroniser for the asynchronous pll LOCKED status.
// Synchronous active-high reset clears the chain to 0.
module drp_lock_sync
    import pll_drp_pkg::*;
#(
    parameter int DEPTH = LOCK_SYNC_DEPTH
)
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [DEPTH-1:0] sync_r;

    // Shift the asynchronous input through DEPTH flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[DEPTH-2:0], async_in};
        end
    end

    assign sync_out = sync_r[DEPTH-1];

endmodule

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration controller for the pll core. On start it holds the
// pll in reset, read-modify-writes one DRP register per streamed config
// entry, then releases reset and waits for the synchronised LOCKED.
// Optional: define PLL_DRP_READBACK_EN to add a verify read after every
// write; a readback mismatch then ends in ERROR with code 3.
// The DRP read-data port is named drp_do because "do" is a keyword.
module pll_drp_reconfig
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 4
)
(
    input  logic              dclk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DRP_AW-1:0] cfg_addr,
    input  logic [DRP_DW-1:0] cfg_mask,
    input  logic [DRP_DW-1:0] cfg_data,
    input  logic              cfg_last,
    output logic [DRP_AW-1:0] daddr,
    output logic [DRP_DW-1:0] di,
    output logic              den,
    output logic              dwe,
    input  logic [DRP_DW-1:0] drp_do,
    input  logic              drdy,
    input  logic              locked,
    output logic              pll_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TMAX_A = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > RST_HOLD) ? TMAX_A : RST_HOLD;
    localparam int CNT_W  = $clog2(TMAX + 1);

    // Counters start at 0 on state entry; the "last" value is the final
    // cycle in which the awaited event is still accepted.
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DRP_DW-1:0] mask_r;
    logic [DRP_DW-1:0] data_r;
    logic              last_r;
    logic              lock_s;

    drp_lock_sync #(.DEPTH(LOCK_SYNC_DEPTH)) u_lock_sync (
        .clk      (dclk),
        .rst      (rst),
        .async_in (locked),
        .sync_out (lock_s)
    );

    // Controller FSM; every output is a register updated on state transitions.
    always_ff @(posedge dclk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            mask_r    <= {DRP_DW{1'b0}};
            data_r    <= {DRP_DW{1'b0}};
            last_r    <= 1'b0;
            cfg_ready <= 1'b0;
            daddr     <= {DRP_AW{1'b0}};
            di        <= {DRP_DW{1'b0}};
            den       <= 1'b0;
            dwe       <= 1'b0;
            pll_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            den  <= 1'b0;
            dwe  <= 1'b0;
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_HOLD;
                        busy     <= 1'b1;
                        pll_rst  <= 1'b1;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                ST_HOLD: begin
                    state_r   <= ST_ENTRY;
                    cfg_ready <= 1'b1;
                end
                ST_ENTRY: begin
                    if (cfg_valid) begin
                        cfg_ready <= 1'b0;
                        daddr     <= cfg_addr;
                        mask_r    <= cfg_mask;
                        data_r    <= cfg_data;
                        last_r    <= cfg_last;
                        den       <= 1'b1;
                        state_r   <= ST_RD;
                    end
                end
                ST_RD: begin
                    state_r <= ST_WRD;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                ST_WRD: begin
                    if (drdy) begin
                        di      <= rmw_merge(drp_do, mask_r, data_r);
                        den     <= 1'b1;
                        dwe     <= 1'b1;
                        state_r <= ST_WR;
                    end else if (cnt_r == DRDY_LAST) begin
                        state_r  <= ST_ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        pll_rst  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WR: begin
                    state_r <= ST_WWR;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                ST_WWR: begin
                    if (drdy) begin
`ifdef PLL_DRP_READBACK_EN
                        den     <= 1'b1;
                        state_r <= ST_RVFY;
`else
                        if (last_r) begin
                            state_r <= ST_RELEASE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            state_r   <= ST_ENTRY;
                            cfg_ready <= 1'b1;
                        end
`endif
                    end else if (cnt_r == DRDY_LAST) begin
                        state_r  <= ST_ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        pll_rst  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef PLL_DRP_READBACK_EN
                ST_RVFY: begin
                    state_r <= ST_WRV;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                ST_WRV: begin
                    if (drdy) begin
                        if (drp_do != di) begin
                            state_r  <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_VERIFY;
                            pll_rst  <= 1'b1;
                        end else if (last_r) begin
                            state_r <= ST_RELEASE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            state_r   <= ST_ENTRY;
                            cfg_ready <= 1'b1;
                        end
                    end else if (cnt_r == DRDY_LAST) begin
                        state_r  <= ST_ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        pll_rst  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_RELEASE: begin
                    if (cnt_r == HOLD_LAST) begin
                        pll_rst <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_WLOCK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WLOCK: begin
                    if (lock_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == LOCK_LAST) begin
                        state_r  <= ST_ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_LOCK;
                        pll_rst  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    if (start) begin
                        state_r  <= ST_HOLD;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        pll_rst  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cfg_ready <= 1'b0;
                    pll_rst   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
